// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: major opcode constants (opcode[6:2]),
// instruction format enum, immediate bounds and the format decoder.
package riscv_pkg;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_REG    = 5'b01100;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} fmt_e;

  // Signed byte-value bounds of the encodable immediates.
  localparam int signed IMM_IS_MIN = -2048;
  localparam int signed IMM_IS_MAX = 2047;
  localparam int signed IMM_B_MIN  = -4096;
  localparam int signed IMM_B_MAX  = 4094;
  localparam int signed IMM_J_MIN  = -1048576;
  localparam int signed IMM_J_MAX  = 1048574;

  // One buffered encoder result.
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_result_t;

  function automatic fmt_e decode_fmt(input logic [4:0] op);
    case (op)
      OP_LUI, OP_AUIPC:          return FMT_U;
      OP_JAL:                    return FMT_J;
      OP_JALR, OP_IMM, OP_LOAD:  return FMT_I;
      OP_STORE:                  return FMT_S;
      OP_BRANCH:                 return FMT_B;
      OP_REG:                    return FMT_R;
      default:                   return FMT_ILL;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I instruction packer: picks the format from opcode[6:2],
// places the fields at their standard bit positions and flags errors.
// Macro INSTR_ENC_RANGE_CHECK_EN adds immediate legality checking; without it
// immediates are truncated silently and only illegal opcodes are errors.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e        fmt;
  logic [6:0]  op_out;
  logic [31:0] packed_instr;
  logic        ill;

  // opcode[1:0] is always rewritten to 2'b11.
  logic unused_opcode_lsbs;
  assign unused_opcode_lsbs = &{1'b0, opcode[1:0]};

  // Format select and field packing.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so no path can infer a latch.
    packed_instr = '0;
    fmt          = decode_fmt(opcode[6:2]);
    op_out       = {opcode[6:2], 2'b11};
    ill          = (fmt == FMT_ILL);
    case (fmt)
      FMT_R: packed_instr = {funct7, rs2, rs1, funct3, rd, op_out};
      FMT_I: packed_instr = {imm[11:0], rs1, funct3, rd, op_out};
      FMT_S: packed_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], op_out};
      FMT_B: packed_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op_out};
      FMT_U: packed_instr = {imm[31:12], rd, op_out};
      FMT_J: packed_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op_out};
      default: packed_instr = '0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic imm_ok;
  int signed simm;

  // Immediate legality per format; a failing result is zeroed.
  always_comb begin
    simm   = $signed(imm);
    imm_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: imm_ok = (simm >= IMM_IS_MIN) && (simm <= IMM_IS_MAX);
      FMT_B:        imm_ok = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX) && !imm[0];
      FMT_J:        imm_ok = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX) && !imm[0];
      FMT_U:        imm_ok = (imm[11:0] == 12'h000);
      default:      imm_ok = 1'b1;
    endcase
    err   = ill || !imm_ok;
    instr = err ? 32'h0000_0000 : packed_instr;
  end
`else
  // Only an illegal opcode is an error; its word is zeroed.
  always_comb begin
    err   = ill;
    instr = ill ? 32'h0000_0000 : packed_instr;
  end
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one request per cycle is packed by instr_pack,
// held in a 2-entry in-order skid buffer, and counted as it leaves.
// Optional macro INSTR_ENC_RANGE_CHECK_EN enables immediate range checking.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  enc_result_t new_res;
  enc_result_t buf0;   // head, visible on the outputs
  enc_result_t buf1;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  instr_pack u_pack (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (new_res.instr),
    .err    (new_res.err)
  );

  assign in_ready  = !rst && (count != 2'd2);
  assign push      = in_valid && in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_instr = buf0.instr;
  assign out_err   = buf0.err;

  // Skid buffer: push into the first free slot, pop shifts buf1 into the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the entries are reset, not just the count, because the head drives out_instr/out_err which must read 0 in reset.
      count <= 2'd0;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      case (count)
        2'd0: begin
          if (push) begin
            buf0  <= new_res;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            buf0 <= new_res;
          end else if (pop) begin
            count <= 2'd0;
          end else if (push) begin
            buf1  <= new_res;
            count <= 2'd2;
          end
        end
        2'd2: begin
          // in_ready is low when full, so only a pop can happen here.
          if (pop) begin
            buf0  <= buf1;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  // Saturating statistics of results accepted downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (pop) begin
      if (buf0.err) begin
        if (cnt_err != '1) cnt_err <= cnt_err + CNT_W'(1);
      end else begin
        if (cnt_ok != '1) cnt_ok <= cnt_ok + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors with literal
// expectations plus a format-rule model and in-order scoreboard checked
// every cycle. Works with and without INSTR_ENC_RANGE_CHECK_EN.
module tb_instr_encoder;

  localparam int CW = 3;  // small counters so saturation is reached
`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] cnt_ok, cnt_err;

  int total = 0;
  int bad   = 0;

  instr_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    logic [31:0] mask;
    mask = (32'h1 << (hi - lo + 1)) - 32'h1;
    return (v >> lo) & mask;
  endfunction

  // Returns {err, instr} for one request, straight from the RV32I format rules.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd_v,
                                        input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] regs;
    int          s;
    bit          ok;
    w    = 32'(op) | 32'h3;
    regs = (32'(rd_v) << 7) | (32'(f3) << 12) | (32'(rs1_v) << 15);
    s    = int'(imm);
    ok   = 1'b1;
    case (op[6:2])
      5'b01101, 5'b00101: begin  // U
        w  = w | (32'(rd_v) << 7) | (imm & 32'hFFFF_F000);
        ok = (imm % 4096) == 0;
      end
      5'b11011: begin            // J
        w  = w | (32'(rd_v) << 7) | (fld(imm,19,12) << 12) | (fld(imm,11,11) << 20)
               | (fld(imm,10,1) << 21) | (fld(imm,20,20) << 31);
        ok = s >= -1048576 && s <= 1048574 && (s % 2) == 0;
      end
      5'b11001, 5'b00100, 5'b00000: begin  // I
        w  = w | regs | (fld(imm,11,0) << 20);
        ok = s >= -2048 && s <= 2047;
      end
      5'b01000: begin            // S
        w  = w | (regs & ~(32'h1F << 7)) | (32'(rs2_v) << 20)
               | (fld(imm,4,0) << 7) | (fld(imm,11,5) << 25);
        ok = s >= -2048 && s <= 2047;
      end
      5'b11000: begin            // B
        w  = w | (regs & ~(32'h1F << 7)) | (32'(rs2_v) << 20)
               | (fld(imm,11,11) << 7) | (fld(imm,4,1) << 8)
               | (fld(imm,10,5) << 25) | (fld(imm,12,12) << 31);
        ok = s >= -4096 && s <= 4094 && (s % 2) == 0;
      end
      5'b01100: begin            // R
        w = w | regs | (32'(rs2_v) << 20) | (32'(f7) << 25);
      end
      default: return {1'b1, 32'h0};
    endcase
    if (RC && !ok) return {1'b1, 32'h0};
    return {1'b0, w};
  endfunction

  // ---------------- per-cycle compare process ----------------
  logic [32:0] sb[$];
  int          exp_ok, exp_err;
  bit          prev_stall;
  logic [31:0] prev_instr;
  logic        prev_err;
  localparam int CMAX = (1 << CW) - 1;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_cnt_ok", 32'(cnt_ok), 32'd0);
      check("rst_cnt_err", 32'(cnt_err), 32'd0);
      sb.delete();
      exp_ok     = 0;
      exp_err    = 0;
      prev_stall = 1'b0;
    end else begin
      check("cnt_ok", 32'(cnt_ok), 32'(exp_ok));
      check("cnt_err", 32'(cnt_err), 32'(exp_err));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_instr", out_instr, prev_instr);
        check("stall_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid === 1'b1 && sb.size() != 0) begin
        check("sb_err", 32'(out_err), 32'(sb[0][32]));
        // Without range checking the word of an illegal opcode is left open.
        if (RC || !sb[0][32]) check("sb_instr", out_instr, sb[0][31:0]);
        if (out_ready) begin
          if (sb[0][32]) begin if (exp_err < CMAX) exp_err++; end
          else           begin if (exp_ok  < CMAX) exp_ok++;  end
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                         input logic [4:0] rs2_v, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
    in_opcode = op; in_rd = rd_v; in_rs1 = rs1_v; in_rs2 = rs2_v;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                      input logic [4:0] rs2_v, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    int n;
    @(posedge clk); #1;
    set_req(op, rd_v, rs1_v, rs2_v, f3, f7, imm);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] instr, input logic err,
                            input bit chk_instr);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    if (chk_instr) check({name, "_instr"}, out_instr, instr);
    check({name, "_err"}, 32'(out_err), 32'(err));
  endtask

  typedef struct {
    logic [6:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
  } vec_t;

  vec_t vecs[13] = '{
    '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF}, // R sub, imm ignored
    '{7'b1100111, 5'd1, 5'd6, 5'd0, 3'd0, 7'h00, -32'sd2048},    // I min
    '{7'b0000011, 5'd7, 5'd2, 5'd0, 3'd2, 7'h00, 32'd2047},      // I max
    '{7'b0010011, 5'd7, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2048},      // I over
    '{7'b0100011, 5'd0, 5'd3, 5'd4, 3'd2, 7'h00, -32'sd2048},    // S min
    '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'd3},         // B odd
    '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'd4094},      // B max
    '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'd4, 7'h00, -32'sd4096},    // B min
    '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'd4, 7'h00, 32'd4096},      // B over
    '{7'b1101111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048574},   // J max
    '{7'b1101111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048576},   // J over
    '{7'b1101111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, -32'sd1048576}, // J min
    '{7'b0010111, 5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001}  // U low bits set
  };

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_req(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Literal encodings.
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    expect_out("addi", 32'h0050_0093, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("cnt_ok_first", 32'(cnt_ok), 32'd1);
    send(7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    expect_out("lui", 32'h1234_5137, 1'b0, 1'b1);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    expect_out("jal", 32'h0080_00EF, 1'b0, 1'b1);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    expect_out("beq", 32'hFE20_8EE3, 1'b0, 1'b1);
    send(7'b0100011, 5'd0, 5'd0, 5'd0, 3'd2, 7'd0, 32'd2048);
    if (RC) expect_out("sw_over", 32'h0000_0000, 1'b1, 1'b1);
    else    expect_out("sw_trunc", 32'h8000_2023, 1'b0, 1'b1);
    send(7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    expect_out("illegal", 32'h0, 1'b1, RC);
    repeat (2) @(negedge clk);
    check("cnt_ok_mid", 32'(cnt_ok), RC ? 32'd4 : 32'd5);
    check("cnt_err_mid", 32'(cnt_err), RC ? 32'd2 : 32'd1);

    // Boundary vectors, checked by the model (drives counters to saturation).
    foreach (vecs[i])
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
    repeat (3) @(negedge clk);
    check("cnt_ok_sat", 32'(cnt_ok), 32'd7);

    // Backpressure: 3 back-to-back offers with out_ready low.
    @(posedge clk); #1 out_ready = 1'b0;
    send(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    @(posedge clk); #1;
    set_req(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    check("full_ready_low", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("order_a", out_instr, 32'h0010_0193);
    @(posedge clk); #1;
    @(negedge clk);
    check("order_b", out_instr, 32'h0010_0213);
    check("ready_again", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("order_c", out_instr, 32'h0010_0293);
    repeat (2) @(negedge clk);

    // Reset with two results buffered.
    @(posedge clk); #1 out_ready = 1'b0;
    send(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    send(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_cnt_ok", 32'(cnt_ok), 32'd0);
    check("rst_async_cnt_err", 32'(cnt_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(in_ready), 32'd1);
    check("rst_release_valid", 32'(out_valid), 32'd0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
